// File: rtl/eth_pixel_rx_parser.sv
// Receive-domain byte parser: preamble/SFD check, 8-byte pixel header extraction,
// and payload packing into 32-bit pixel words with error flagging.
module eth_pixel_rx_parser #(
    parameter logic [15:0] MAX_PIX = 16'd1024,
    parameter logic [15:0] RSV_TAG = 16'h0888
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        hdr_valid,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic [15:0] pix_len,
    output logic        pix_valid,
    output logic [31:0] pix_data,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [1:0]  err_code
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] HDR   = 3'd2;
    localparam logic [2:0] PAY   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam logic [1:0] ERR_PRE   = 2'd1;
    localparam logic [1:0] ERR_HDR   = 2'd2;
    localparam logic [1:0] ERR_TRUNC = 2'd3;

    logic [2:0]  state;
    logic [2:0]  pre_cnt;
    logic [2:0]  byte_cnt;
    logic [15:0] word_cnt;
    logic [1:0]  biw;
    logic [55:0] hdr_sr;
    logic [23:0] word_sr;

    // Fields of the completed header as seen while the last header byte is on the bus.
    logic [15:0] h_row, h_col, h_len, h_rsv;
    assign h_row = hdr_sr[55:40];
    assign h_col = hdr_sr[39:24];
    assign h_len = hdr_sr[23:8];
    assign h_rsv = {hdr_sr[7:0], gmii_rxd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            biw       <= '0;
            hdr_sr    <= '0;
            word_sr   <= '0;
            hdr_valid <= 1'b0;
            row       <= '0;
            col       <= '0;
            pix_len   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            hdr_valid <= 1'b0;
            pix_valid <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            case (state)
                IDLE: if (gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55) begin
                        state   <= PRE;
                        pre_cnt <= 3'd1;
                    end else begin
                        state    <= DRAIN;
                        pkt_err  <= 1'b1;
                        err_code <= ERR_PRE;
                    end
                end
                PRE: if (!gmii_rx_dv) begin
                    state    <= IDLE;
                    pkt_err  <= 1'b1;
                    err_code <= ERR_TRUNC;
                end else if (gmii_rxd == 8'h55 && pre_cnt < 3'd7) begin
                    pre_cnt <= pre_cnt + 3'd1;
                end else if (gmii_rxd == 8'hD5 && pre_cnt == 3'd7) begin
                    state    <= HDR;
                    byte_cnt <= '0;
                end else begin
                    state    <= DRAIN;
                    pkt_err  <= 1'b1;
                    err_code <= ERR_PRE;
                end
                HDR: if (!gmii_rx_dv) begin
                    state    <= IDLE;
                    pkt_err  <= 1'b1;
                    err_code <= ERR_TRUNC;
                end else begin
                    hdr_sr   <= {hdr_sr[47:0], gmii_rxd};
                    byte_cnt <= byte_cnt + 3'd1;
                    if (byte_cnt == 3'd7) begin
                        if (h_rsv != RSV_TAG || h_len > MAX_PIX) begin
                            state    <= DRAIN;
                            pkt_err  <= 1'b1;
                            err_code <= ERR_HDR;
                        end else begin
                            hdr_valid <= 1'b1;
                            row       <= h_row;
                            col       <= h_col;
                            pix_len   <= h_len;
                            word_cnt  <= '0;
                            biw       <= '0;
                            if (h_len == 16'd0) begin
                                pkt_done <= 1'b1;
                                state    <= DRAIN;
                            end else begin
                                state <= PAY;
                            end
                        end
                    end
                end
                PAY: if (!gmii_rx_dv) begin
                    // a partially assembled word is simply dropped
                    state    <= IDLE;
                    pkt_err  <= 1'b1;
                    err_code <= ERR_TRUNC;
                end else begin
                    word_sr <= {word_sr[15:0], gmii_rxd};
                    biw     <= biw + 2'd1;
                    if (biw == 2'd3) begin
                        pix_valid <= 1'b1;
                        pix_data  <= {word_sr, gmii_rxd};
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt == pix_len - 16'd1) begin
                            pkt_done <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: if (!gmii_rx_dv) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pixel_rx_parser.sv
// Directed bench for eth_pixel_rx_parser: valid, empty, malformed, truncated,
// back-to-back and mid-packet-reset frames with hand-computed expectations.
module tb_eth_pixel_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        hdr_valid, pix_valid, pkt_done, pkt_err;
    logic [15:0] row, col, pix_len;
    logic [31:0] pix_data;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;

    eth_pixel_rx_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rxd   (gmii_rxd),
        .hdr_valid  (hdr_valid),
        .row        (row),
        .col        (col),
        .pix_len    (pix_len),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge away from register updates.
    int          n_hdr = 0, n_pix = 0, n_done = 0, n_err = 0, n_both = 0;
    logic [15:0] cap_row, cap_col, cap_len;
    logic [1:0]  cap_code;
    logic        cap_hdr_done;
    logic [31:0] words [0:63];

    always @(negedge clk) begin
        if (hdr_valid) begin
            n_hdr++;
            cap_row = row;
            cap_col = col;
            cap_len = pix_len;
            cap_hdr_done = pkt_done;
        end
        if (pix_valid) begin
            words[n_pix % 64] = pix_data;
            n_pix++;
        end
        if (pkt_done) begin
            n_done++;
            if (pkt_err) n_both++;
        end
        if (pkt_err) begin
            n_err++;
            cap_code = err_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Each call presents one cycle of input and returns just after the following
    // falling edge, so outputs reflect the byte just sampled.
    task automatic send_byte(input logic [7:0] b);
        gmii_rx_dv = 1'b1;
        gmii_rxd   = b;
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            gmii_rx_dv = 1'b0;
            gmii_rxd   = 8'h00;
            @(negedge clk); #1;
        end
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic header(input logic [15:0] r, input logic [15:0] c,
                          input logic [15:0] l, input logic [15:0] t);
        send_byte(r[15:8]); send_byte(r[7:0]);
        send_byte(c[15:8]); send_byte(c[7:0]);
        send_byte(l[15:8]); send_byte(l[7:0]);
        send_byte(t[15:8]); send_byte(t[7:0]);
    endtask

    task automatic payload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    endtask

    int b_hdr, b_pix, b_done, b_err;
    task automatic snap();
        b_hdr = n_hdr; b_pix = n_pix; b_done = n_done; b_err = n_err;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_done_err",  32'({pkt_done, pkt_err}), 32'd0);
        chk("rst_fields",    32'({row, col}), 32'd0);
        chk("rst_len_code",  32'({pix_len, 14'd0, err_code}), 32'd0);
        chk("rst_pix_data",  pix_data, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Valid two-word frame
        snap();
        preamble();
        header(16'h0001, 16'h0203, 16'h0002, 16'h0888);
        chk("v_hdr_pulse", 32'(hdr_valid), 32'd1);
        payload(8, 8'h00);
        chk("v_last_pulse", 32'({pix_valid, pkt_done, pkt_err}), 32'b110);
        idle(2);
        chk("v_row",  32'(cap_row), 32'h0001);
        chk("v_col",  32'(cap_col), 32'h0203);
        chk("v_len",  32'(cap_len), 32'h0002);
        chk("v_npix", 32'(n_pix - b_pix), 32'd2);
        chk("v_w0",   words[b_pix % 64], 32'h00010203);
        chk("v_w1",   words[(b_pix + 1) % 64], 32'h04050607);
        chk("v_done", 32'(n_done - b_done), 32'd1);
        chk("v_err",  32'(n_err - b_err), 32'd0);

        // Zero-length frame
        snap();
        preamble();
        header(16'h0001, 16'h0203, 16'h0000, 16'h0888);
        chk("z_hdr_and_done", 32'({hdr_valid, pkt_done}), 32'b11);
        idle(2);
        chk("z_npix", 32'(n_pix - b_pix), 32'd0);
        chk("z_done", 32'(n_done - b_done), 32'd1);
        chk("z_err",  32'(n_err - b_err), 32'd0);

        // Bad SFD, rest of frame ignored
        snap();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD4);
        chk("sfd_err_now", 32'({pkt_err, err_code}), 32'b101);
        header(16'h0001, 16'h0203, 16'h0002, 16'h0888);
        idle(2);
        chk("sfd_nerr", 32'(n_err - b_err), 32'd1);
        chk("sfd_nhdr", 32'(n_hdr - b_hdr), 32'd0);

        // Bad reserved tag
        snap();
        preamble();
        header(16'h0001, 16'h0203, 16'h0002, 16'h0889);
        chk("rsv_err_now", 32'({pkt_err, err_code, hdr_valid}), 32'b1100);
        payload(8, 8'h00);
        idle(2);
        chk("rsv_nhdr", 32'(n_hdr - b_hdr), 32'd0);
        chk("rsv_npix", 32'(n_pix - b_pix), 32'd0);

        // Pixel count one over the limit, then exactly at the limit
        snap();
        preamble();
        header(16'h0001, 16'h0203, 16'd1025, 16'h0888);
        idle(2);
        chk("len_big_code", 32'(cap_code), 32'd2);
        chk("len_big_nhdr", 32'(n_hdr - b_hdr), 32'd0);
        snap();
        preamble();
        header(16'h0009, 16'h000A, 16'd1024, 16'h0888);
        chk("len_max_hdr", 32'({hdr_valid, pkt_err}), 32'b10);
        idle(1);
        chk("len_max_trunc", 32'({pkt_err, err_code}), 32'b111);

        // Truncated payload: one full word then 2 stray bytes
        snap();
        preamble();
        header(16'h0001, 16'h0203, 16'h0002, 16'h0888);
        payload(6, 8'h00);
        idle(1);
        chk("tr_err_now", 32'({pkt_err, err_code}), 32'b111);
        idle(1);
        chk("tr_npix", 32'(n_pix - b_pix), 32'd1);
        chk("tr_w0",   words[b_pix % 64], 32'h00010203);
        chk("tr_done", 32'(n_done - b_done), 32'd0);
        chk("tr_nerr", 32'(n_err - b_err), 32'd1);

        // Back-to-back frames, trailing bytes on the first
        snap();
        preamble();
        header(16'h0005, 16'h0006, 16'h0001, 16'h0888);
        payload(4, 8'h10);
        payload(4, 8'hAA);
        idle(1);
        preamble();
        header(16'h0007, 16'h0008, 16'h0002, 16'h0888);
        payload(8, 8'h20);
        idle(2);
        chk("bb_nhdr",  32'(n_hdr - b_hdr), 32'd2);
        chk("bb_done",  32'(n_done - b_done), 32'd2);
        chk("bb_err",   32'(n_err - b_err), 32'd0);
        chk("bb_npix",  32'(n_pix - b_pix), 32'd3);
        chk("bb_w0",    words[b_pix % 64], 32'h10111213);
        chk("bb_w1",    words[(b_pix + 1) % 64], 32'h20212223);
        chk("bb_w2",    words[(b_pix + 2) % 64], 32'h24252627);
        chk("bb_row2",  32'({cap_row, cap_col}), 32'h00070008);

        // Reset in the middle of a payload
        preamble();
        header(16'h0003, 16'h0004, 16'h0004, 16'h0888);
        payload(5, 8'h30);
        rst_n = 1'b0;
        #1;
        chk("mr_clear_data", pix_data, 32'd0);
        chk("mr_clear_hdr",  32'({row, col}), 32'd0);
        chk("mr_clear_len",  32'(pix_len), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        send_byte(8'h35);
        chk("mr_newframe_err", 32'({pkt_err, err_code}), 32'b101);
        payload(3, 8'h36);
        idle(2);

        chk("never_done_and_err", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/eth_pixel_rx_parser.md
# eth_pixel_rx_parser

Byte-level receive parser sitting directly downstream of the RGMII DDR-to-SDR receive stage, in the receive clock domain. It consumes the 8-bit GMII-style stream (data-valid plus byte) and checks the 7×0x55 + 0xD5 preamble. It then extracts the 8-byte pixel header (row, column, pixel count, reserved tag) and emits the payload as 32-bit pixel words. It flags malformed or truncated packets so the downstream pixel writer never sees a partial frame line.

## Interface
- MAX_PIX, 16'd1024, largest accepted pixel count; larger header values are rejected
- RSV_TAG, 16'h0888, required value of the 2 reserved header bytes
- clk  in  1  receive-domain byte clock (one byte per cycle when gmii_rx_dv=1)
- rst_n  in  1  asynchronous active-low reset
- gmii_rx_dv  in  1  byte valid / frame envelope from RGMII receive stage
- gmii_rxd  in  8  received byte
- hdr_valid  out  1  one-cycle pulse, header accepted
- row  out  16  header bytes 0-1, big-endian; held until next hdr_valid
- col  out  16  header bytes 2-3, big-endian; held
- pix_len  out  16  header bytes 4-5, big-endian; held
- pix_valid  out  1  one-cycle pulse per assembled pixel word
- pix_data  out  32  pixel word, first received byte in [31:24]
- pkt_done  out  1  one-cycle pulse, last pixel word delivered
- pkt_err  out  1  one-cycle pulse, packet aborted
- err_code  out  2  valid with pkt_err: 1 bad preamble/SFD, 2 bad header, 3 truncated

## Operation
- States: IDLE, PRE, HDR, PAY, DRAIN.
- IDLE: on dv=1, byte 0x55 → PRE with pre_cnt=1; any other byte → DRAIN with pkt_err, code 1.
- PRE: byte 0x55 with pre_cnt<7 → pre_cnt+1. Byte 0xD5 with pre_cnt==7 → HDR, byte_cnt=0. Anything else → DRAIN, code 1.
- HDR: shift 8 bytes into header register. On byte 7, check reserved==RSV_TAG and len<=MAX_PIX; failing either → DRAIN, code 2.
- On HDR pass with len==0: pulse hdr_valid and pkt_done together, → DRAIN.
- On HDR pass with len>0: pulse hdr_valid, → PAY, word_cnt=0, byte-in-word=0.
- PAY: pack bytes MSB-first. Every 4th byte: pix_valid, word_cnt+1. On word_cnt==len-1 completion: pkt_done with that final pix_valid, → DRAIN.
- DRAIN: ignore bytes (trailing FCS/padding tolerated, no error); dv=0 → IDLE.
- dv falling in PRE/HDR/PAY: pkt_err code 3, → IDLE directly. No pix_valid for a partial word.
- dv=0 in IDLE: no action. Cycles with dv=0 never advance counters.
- Counters: pre_cnt 3 bits; byte_cnt 3 bits; word_cnt 16 bits, compared against latched len; byte-in-word 2 bits wraps 3→0.
- pkt_err is never asserted together with pkt_done; at most one of pkt_done/pkt_err per frame.

## Timing
- All outputs registered. Each pulse fires the cycle after the clk edge that samples the triggering byte.
- hdr_valid: 1 cycle after header byte 7 (second reserved byte). row/col/pix_len update in that same cycle.
- pix_valid/pix_data: 1 cycle after 4th byte of each word. pix_data holds until next pix_valid.
- Truncation pkt_err: 1 cycle after the first sample with dv=0.
- Back-to-back frames: one dv=0 cycle between frames suffices; the next frame's first 0x55 is accepted from IDLE.
- Reset values: all pulses 0, row/col/pix_len/pix_data 0, err_code 0, state IDLE, counters 0.
- Reset asserted mid-packet: immediate return to IDLE. Remaining bytes of that frame are handled as a new frame from IDLE (first non-0x55 byte → code 1, then DRAIN).
- Throughput: 1 byte/cycle sustained, no back-pressure. Downstream must accept every pix_valid.

## Test plan
- Valid frame: 7×0x55, 0xD5, 00 01 02 03, 00 02, 08 88, bytes 00..07 → hdr_valid with row=0x0001, col=0x0203, pix_len=2. Then pix_data 0x00010203 and 0x04050607, pkt_done with second word, no pkt_err.
- len=0 frame, same header with 00 00 → hdr_valid and pkt_done in same cycle, no pix_valid.
- Bad SFD: 7×0x55 then 0xD4 → pkt_err code 1 one cycle later. Rest of frame ignored until dv low.
- Reserved 08 89, or len=MAX_PIX+1 → pkt_err code 2, no hdr_valid.
- dv dropped after 6 payload bytes of len=2 → one pix_valid (0x00010203), then pkt_err code 3, no pkt_done.
- Two back-to-back valid frames separated by one idle cycle, plus 4 trailing bytes after frame 1 → both frames parsed fully, trailing bytes produce no pulses. Asserting rst_n=0 mid-payload clears all outputs to 0 the same cycle.
